pipe_mem_wb_skid: RTL and testbench
===================================

// Module: pipe_mem_wb_skid
// PURPOSE
//  Parametrised MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
//  Sits between the data-memory stage and register-file writeback.
//  Lets WB back-pressure MEM without a combinational ready path, and lets hazard logic squash in-flight ops.
//  Adds an x0 write guard and a saturating back-pressure counter.
// PARAMETERS
//  WIDTH        32  data path width of MEMDATA/RESULTOP
//  AW           5   register address width (ARD)
//  ZERO_GUARD   1   1: REGWRITE_OUT forced 0 when ARD_OUT==0; 0: no gating
//  CNT_W        16  width of STALL_CNT
// PORTS
//  clk           in   1      clock, all state updates on rising edge
//  rst           in   1      synchronous reset, active-high
//  FLUSH         in   1      synchronous squash of all held entries
//  VALID_IN      in   1      upstream entry valid
//  READY_OUT     out  1      block can accept an entry this cycle
//  MEMTOREG_IN   in   1      writeback select: 1=memory data, 0=ALU result
//  REGWRITE_IN   in   1      register-file write enable
//  MEMDATA_IN    in   WIDTH  data read from memory
//  RESULTOP_IN   in   WIDTH  ALU result
//  ARD_IN        in   AW     destination register address
//  VALID_OUT     out  1      output entry valid
//  READY_IN      in   1      downstream accepts output entry
//  MEMTOREG_OUT  out  1      registered MEMTOREG
//  REGWRITE_OUT  out  1      registered REGWRITE, gated by VALID_OUT (and ZERO_GUARD)
//  MEMDATA_OUT   out  WIDTH  registered MEMDATA
//  RESULTOP_OUT  out  WIDTH  registered RESULTOP
//  ARD_OUT       out  AW     registered ARD
//  STALL_CNT     out  CNT_W  cycles with VALID_OUT=1 and READY_IN=0, saturating
// BEHAVIOUR
//  Storage: main reg M (drives outputs) and skid reg S. Each has a valid bit.
//  Handshakes: acc = VALID_IN&READY_OUT; ret = VALID_OUT&READY_IN.
//  READY_OUT = !S.valid & !rst, from registered state only. No IN->OUT combinational path.
//  VALID_OUT = M.valid.
//  Latency: 1 cycle from acc to VALID_OUT when M is empty or retiring.
//  Per edge, priority order rst > FLUSH > normal operation:
//   rst:   M,S valid=0; all payload outputs 0; STALL_CNT=0.
//   FLUSH: M,S valid=0; an entry accepted in the same cycle is dropped; payload may hold; STALL_CNT kept.
//   !M.valid|ret: M <= S if S.valid, else the input if acc, else M.valid=0. S.valid <= 0.
//   M.valid & !ret & acc: S <= input. READY_OUT drops next cycle.
//  Order is preserved: S always drains into M before a new input is accepted.
//  Throughput: 1 entry/cycle while READY_IN=1. Entries are never lost or duplicated.
//  REGWRITE_OUT = M.regwrite & M.valid & (ZERO_GUARD ? ARD_OUT!=0 : 1).
//  STALL_CNT: +1 per cycle with VALID_OUT&!READY_IN. Holds at 2^CNT_W-1. Cleared only by rst.
//  Payload outputs are don't-care (not X) when VALID_OUT=0. After rst they are exactly 0.
// STRUCTURE
//  Package pipe_pkg holds:
//   typedef struct packed {memtoreg, regwrite, memdata[WIDTH], resultop[WIDTH], ard[AW]} mem_wb_t
//   localparam AW_DEF=5
//  Sub-module pipe_skid_reg #(PW): generic payload skid register (M+S, flush, handshake).
//  Top instantiates it with PW=$bits(mem_wb_t).
//  Top adds REGWRITE gating and STALL_CNT.
// TESTING
//  1 rst=1 two cycles -> VALID_OUT=0, READY_OUT=0, all payload outs 0, STALL_CNT=0.
//    Release rst -> READY_OUT=1 next cycle.
//  2 Pass-through, READY_IN=1: VALID_IN=1 with {1,1,DEADBEEF,12345678,10101}
//    -> next cycle VALID_OUT=1, outputs equal input, REGWRITE_OUT=1.
//    Back-to-back {0,0,FFFFFFFF,87654321,01110} follows one cycle later.
//  3 Back-pressure: READY_IN=0, push A=...01, B=...02.
//    -> B lands in S, READY_OUT=0, outputs hold A, STALL_CNT increments each cycle.
//    READY_IN=1 -> A then B retire in order, READY_OUT=1 again.
//  4 FLUSH with M and S full plus VALID_IN=1
//    -> next cycle VALID_OUT=0, REGWRITE_OUT=0, READY_OUT=1; no flushed entry ever appears.
//  5 ZERO_GUARD=1: REGWRITE_IN=1, ARD_IN=0 -> REGWRITE_OUT=0.
//    ARD_IN=00011 -> REGWRITE_OUT=1.
//  6 rst mid-stall with STALL_CNT=7 -> counter 0, both entries gone.
//    CNT_W=3 stall of 10 cycles -> STALL_CNT saturates at 7.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared MEM->WB definitions: default widths, the writeback bundle layout
// and a helper that sizes a payload for arbitrary widths.
package pipe_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int AW_DEF    = 5;

   // Writeback bundle, MSB first; the pipeline packs its payload in this order
   typedef struct packed {
      logic                 memtoreg;
      logic                 regwrite;
      logic [WIDTH_DEF-1:0] memdata;
      logic [WIDTH_DEF-1:0] resultop;
      logic [AW_DEF-1:0]    ard;
   } mem_wb_t;

   // Payload width of a mem_wb_t-shaped bundle with non-default widths
   function automatic int mem_wb_bits(input int w, input int aw);
      return 2 + 2 * w + aw;
   endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry skid register: main slot M drives the output, skid
// slot S absorbs one entry when downstream stalls, so upstream ready is
// purely registered. Ports: clk, rst (sync, active-high), flush,
// up_valid/up_ready/up_data (producer side), dn_valid/dn_ready/dn_data
// (consumer side).
module pipe_skid_reg #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [PW-1:0] up_data,
   output logic          dn_valid,
   input  logic          dn_ready,
   output logic [PW-1:0] dn_data
);

   logic          m_valid;
   logic          s_valid;
   logic [PW-1:0] m_data;
   logic [PW-1:0] s_data;
   logic          acc;
   logic          ret;

   // Ready depends only on state (plus reset), never on dn_ready
   assign up_ready = !s_valid && !rst;
   assign acc      = up_valid && up_ready;
   assign ret      = m_valid && dn_ready;
   assign dn_valid = m_valid;
   assign dn_data  = m_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_data  <= '0;
         s_data  <= '0;
      end else if (flush) begin
         // Payload is left as is; only the valid bits matter
         m_valid <= 1'b0;
         s_valid <= 1'b0;
      end else if (!m_valid || ret) begin
         // S is older than anything at the input, so it drains first
         if (s_valid) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
         end else if (acc) begin
            m_data  <= up_data;
            m_valid <= 1'b1;
         end else begin
            m_valid <= 1'b0;
         end
         s_valid <= 1'b0;
      end else if (acc) begin
         s_data  <= up_data;
         s_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/pipe_mem_wb_skid.sv
// MEM->WB pipeline register with skid buffer, flush, x0 write guard and
// saturating back-pressure counter. Ports: clk, rst, FLUSH, VALID_IN/
// READY_OUT + MEM payload in, VALID_OUT/READY_IN + WB payload out, STALL_CNT.
module pipe_mem_wb_skid
   import pipe_pkg::*;
#(
   parameter int WIDTH      = WIDTH_DEF,
   parameter int AW         = AW_DEF,
   parameter int ZERO_GUARD = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             FLUSH,
   input  logic             VALID_IN,
   output logic             READY_OUT,
   input  logic             MEMTOREG_IN,
   input  logic             REGWRITE_IN,
   input  logic [WIDTH-1:0] MEMDATA_IN,
   input  logic [WIDTH-1:0] RESULTOP_IN,
   input  logic [AW-1:0]    ARD_IN,
   output logic             VALID_OUT,
   input  logic             READY_IN,
   output logic             MEMTOREG_OUT,
   output logic             REGWRITE_OUT,
   output logic [WIDTH-1:0] MEMDATA_OUT,
   output logic [WIDTH-1:0] RESULTOP_OUT,
   output logic [AW-1:0]    ARD_OUT,
   output logic [CNT_W-1:0] STALL_CNT
);

   // Equals $bits(mem_wb_t) at default widths
   localparam int PW = mem_wb_bits(WIDTH, AW);

   logic [PW-1:0] in_pl;
   logic [PW-1:0] out_pl;
   logic          m_regwrite;
   logic          ard_ok;

   assign in_pl = {MEMTOREG_IN, REGWRITE_IN, MEMDATA_IN,
                   RESULTOP_IN, ARD_IN};

   pipe_skid_reg #(
      .PW(PW)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .flush   (FLUSH),
      .up_valid(VALID_IN),
      .up_ready(READY_OUT),
      .up_data (in_pl),
      .dn_valid(VALID_OUT),
      .dn_ready(READY_IN),
      .dn_data (out_pl)
   );

   assign {MEMTOREG_OUT, m_regwrite, MEMDATA_OUT,
           RESULTOP_OUT, ARD_OUT} = out_pl;

   // Writes to x0 are architecturally discarded; suppress them here
   assign ard_ok = (ZERO_GUARD != 0) ? (ARD_OUT != '0) : 1'b1;

   assign REGWRITE_OUT = m_regwrite && VALID_OUT && ard_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         STALL_CNT <= '0;
      end else if (VALID_OUT && !READY_IN
                   && (STALL_CNT != {CNT_W{1'b1}})) begin
         STALL_CNT <= STALL_CNT + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_mem_wb_skid.sv
// Self-checking bench for pipe_mem_wb_skid: scenario tasks plus an
// in-order scoreboard of accepted entries checked at retirement.
module tb_pipe_mem_wb_skid;
   import pipe_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        FLUSH = 1'b0;
   logic        VALID_IN = 1'b0;
   logic        READY_IN = 1'b0;
   logic        MEMTOREG_IN = 1'b0;
   logic        REGWRITE_IN = 1'b0;
   logic [31:0] MEMDATA_IN = '0;
   logic [31:0] RESULTOP_IN = '0;
   logic [4:0]  ARD_IN = '0;

   logic        READY_OUT, VALID_OUT, MEMTOREG_OUT, REGWRITE_OUT;
   logic [31:0] MEMDATA_OUT, RESULTOP_OUT;
   logic [4:0]  ARD_OUT;
   logic [15:0] STALL_CNT;

   logic        READY_OUT2, VALID_OUT2, MEMTOREG_OUT2, REGWRITE_OUT2;
   logic [31:0] MEMDATA_OUT2, RESULTOP_OUT2;
   logic [4:0]  ARD_OUT2;
   logic [2:0]  STALL_CNT2;

   int n_cmp = 0;
   int n_bad = 0;
   mem_wb_t q[$];
   mem_wb_t got, got2;

   assign got  = {MEMTOREG_OUT, REGWRITE_OUT, MEMDATA_OUT,
                  RESULTOP_OUT, ARD_OUT};
   assign got2 = {MEMTOREG_OUT2, REGWRITE_OUT2, MEMDATA_OUT2,
                  RESULTOP_OUT2, ARD_OUT2};

   always #5 clk = ~clk;

   pipe_mem_wb_skid dut (
      .clk(clk), .rst(rst), .FLUSH(FLUSH),
      .VALID_IN(VALID_IN), .READY_OUT(READY_OUT),
      .MEMTOREG_IN(MEMTOREG_IN), .REGWRITE_IN(REGWRITE_IN),
      .MEMDATA_IN(MEMDATA_IN), .RESULTOP_IN(RESULTOP_IN),
      .ARD_IN(ARD_IN), .VALID_OUT(VALID_OUT), .READY_IN(READY_IN),
      .MEMTOREG_OUT(MEMTOREG_OUT), .REGWRITE_OUT(REGWRITE_OUT),
      .MEMDATA_OUT(MEMDATA_OUT), .RESULTOP_OUT(RESULTOP_OUT),
      .ARD_OUT(ARD_OUT), .STALL_CNT(STALL_CNT)
   );

   pipe_mem_wb_skid #(.CNT_W(3)) dut2 (
      .clk(clk), .rst(rst), .FLUSH(FLUSH),
      .VALID_IN(VALID_IN), .READY_OUT(READY_OUT2),
      .MEMTOREG_IN(MEMTOREG_IN), .REGWRITE_IN(REGWRITE_IN),
      .MEMDATA_IN(MEMDATA_IN), .RESULTOP_IN(RESULTOP_IN),
      .ARD_IN(ARD_IN), .VALID_OUT(VALID_OUT2), .READY_IN(READY_IN),
      .MEMTOREG_OUT(MEMTOREG_OUT2), .REGWRITE_OUT(REGWRITE_OUT2),
      .MEMDATA_OUT(MEMDATA_OUT2), .RESULTOP_OUT(RESULTOP_OUT2),
      .ARD_OUT(ARD_OUT2), .STALL_CNT(STALL_CNT2)
   );

   function automatic mem_wb_t mk(input logic m, input logic w,
                                  input logic [31:0] d,
                                  input logic [31:0] r,
                                  input logic [4:0] a);
      mem_wb_t p;
      p.memtoreg = m;
      p.regwrite = w;
      p.memdata  = d;
      p.resultop = r;
      p.ard      = a;
      return p;
   endfunction

   // Retirement: compare against oldest accepted entry; acceptance: push
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
      end else begin
         if (VALID_OUT && READY_IN) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_spurious: retired %h, none expected",
                        got);
            end else begin
               mem_wb_t e;
               e = q.pop_front();
               if (got !== e) begin
                  n_bad++;
                  $display("FAIL sb_data: got %h want %h", got, e);
               end
            end
         end
         if (FLUSH) begin
            q.delete();
         end else if (VALID_IN && READY_OUT) begin
            mem_wb_t e;
            e = mk(MEMTOREG_IN, REGWRITE_IN && (ARD_IN != 5'd0),
                   MEMDATA_IN, RESULTOP_IN, ARD_IN);
            q.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input mem_wb_t p);
      VALID_IN    = v;
      MEMTOREG_IN = p.memtoreg;
      REGWRITE_IN = p.regwrite;
      MEMDATA_IN  = p.memdata;
      RESULTOP_IN = p.resultop;
      ARD_IN      = p.ard;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, mk(0, 0, 0, 0, 0));
      READY_IN = 1'b0;
      tick();
      tick();
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b0) begin
         n_bad++; $display("FAIL rst_valid: got %b want 0", VALID_OUT);
      end
      n_cmp++;
      if (READY_OUT !== 1'b0) begin
         n_bad++; $display("FAIL rst_ready: got %b want 0", READY_OUT);
      end
      n_cmp++;
      if (got !== '0) begin
         n_bad++; $display("FAIL rst_payload: got %h want 0", got);
      end
      n_cmp++;
      if (STALL_CNT !== 16'd0) begin
         n_bad++; $display("FAIL rst_cnt: got %0d want 0", STALL_CNT);
      end
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (READY_OUT !== 1'b1) begin
         n_bad++; $display("FAIL rst_release: ready %b want 1", READY_OUT);
      end
      tick();
   endtask

   task automatic test_pass();
      mem_wb_t a, b;
      a = mk(1, 1, 32'hDEADBEEF, 32'h12345678, 5'b10101);
      b = mk(0, 0, 32'hFFFFFFFF, 32'h87654321, 5'b01110);
      READY_IN = 1'b1;
      drive(1'b1, a);
      tick();
      drive(1'b1, b);
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b1 || got !== a) begin
         n_bad++; $display("FAIL pass_a: valid %b got %h want %h",
                           VALID_OUT, got, a);
      end
      n_cmp++;
      if (REGWRITE_OUT !== 1'b1) begin
         n_bad++; $display("FAIL pass_rw: got %b want 1", REGWRITE_OUT);
      end
      tick();
      drive(1'b0, b);
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b1 || got !== b) begin
         n_bad++; $display("FAIL pass_b: valid %b got %h want %h",
                           VALID_OUT, got, b);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b0 || q.size() != 0) begin
         n_bad++; $display("FAIL pass_drain: valid %b pending %0d want 0/0",
                           VALID_OUT, q.size());
      end
      tick();
   endtask

   task automatic test_backpressure();
      mem_wb_t a, b;
      a = mk(1, 1, 32'h1, 32'h1, 5'd1);
      b = mk(0, 1, 32'h2, 32'h2, 5'd2);
      READY_IN = 1'b0;
      drive(1'b1, a);
      tick();
      drive(1'b1, b);
      @(negedge clk);
      n_cmp++;
      if (got !== a || READY_OUT !== 1'b1 || STALL_CNT !== 16'd0) begin
         n_bad++; $display("FAIL bp_first: got %h rdy %b cnt %0d want %h 1 0",
                           got, READY_OUT, STALL_CNT, a);
      end
      tick();
      drive(1'b0, b);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if (got !== a || READY_OUT !== 1'b0 || STALL_CNT !== 16'(i)) begin
            n_bad++;
            $display("FAIL bp_hold: got %h rdy %b cnt %0d want %h 0 %0d",
                     got, READY_OUT, STALL_CNT, a, i);
         end
         tick();
      end
      READY_IN = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (got !== a || STALL_CNT !== 16'd5) begin
         n_bad++; $display("FAIL bp_ret_a: got %h cnt %0d want %h 5",
                           got, STALL_CNT, a);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (got !== b || VALID_OUT !== 1'b1 || READY_OUT !== 1'b1) begin
         n_bad++; $display("FAIL bp_ret_b: got %h v %b rdy %b want %h 1 1",
                           got, VALID_OUT, READY_OUT, b);
      end
      tick();
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b0 || q.size() != 0 || STALL_CNT !== 16'd5) begin
         n_bad++; $display("FAIL bp_drain: v %b pend %0d cnt %0d want 0 0 5",
                           VALID_OUT, q.size(), STALL_CNT);
      end
      tick();
   endtask

   task automatic test_flush();
      READY_IN = 1'b0;
      drive(1'b1, mk(1, 1, 32'hC, 32'hC, 5'd12));
      tick();
      drive(1'b1, mk(1, 1, 32'hD, 32'hD, 5'd13));
      tick();
      drive(1'b1, mk(1, 1, 32'hE, 32'hE, 5'd14));
      FLUSH = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (READY_OUT !== 1'b0 || VALID_OUT !== 1'b1) begin
         n_bad++; $display("FAIL fl_full: rdy %b v %b want 0 1",
                           READY_OUT, VALID_OUT);
      end
      tick();
      FLUSH = 1'b0;
      drive(1'b0, mk(0, 0, 0, 0, 0));
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b0 || REGWRITE_OUT !== 1'b0
          || READY_OUT !== 1'b1 || STALL_CNT !== 16'd7) begin
         n_bad++; $display("FAIL fl_after: v %b rw %b rdy %b cnt %0d want 0 0 1 7",
                           VALID_OUT, REGWRITE_OUT, READY_OUT, STALL_CNT);
      end
      drive(1'b1, mk(0, 1, 32'hF, 32'hF, 5'd15));
      tick();
      drive(1'b1, mk(1, 1, 32'h6, 32'h6, 5'd16));
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      drive(1'b0, mk(0, 0, 0, 0, 0));
      READY_IN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
            n_bad++; $display("FAIL fl_leak: v %b rdy %b want 0 1",
                              VALID_OUT, READY_OUT);
         end
         tick();
      end
      n_cmp++;
      if (STALL_CNT !== 16'd8) begin
         n_bad++; $display("FAIL fl_cnt: got %0d want 8", STALL_CNT);
      end
   endtask

   task automatic test_zero_guard();
      READY_IN = 1'b1;
      drive(1'b1, mk(0, 1, 32'h55, 32'hAA, 5'd0));
      tick();
      drive(1'b1, mk(0, 1, 32'h66, 32'hBB, 5'b00011));
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b1 || REGWRITE_OUT !== 1'b0) begin
         n_bad++; $display("FAIL zg_x0: v %b rw %b want 1 0",
                           VALID_OUT, REGWRITE_OUT);
      end
      tick();
      drive(1'b0, mk(0, 0, 0, 0, 0));
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b1 || REGWRITE_OUT !== 1'b1) begin
         n_bad++; $display("FAIL zg_x3: v %b rw %b want 1 1",
                           VALID_OUT, REGWRITE_OUT);
      end
      tick();
      tick();
   endtask

   task automatic test_rst_mid_stall();
      rst = 1'b1;
      drive(1'b0, mk(0, 0, 0, 0, 0));
      tick();
      rst = 1'b0;
      READY_IN = 1'b0;
      drive(1'b1, mk(1, 1, 32'h11, 32'h11, 5'd17));
      tick();
      drive(1'b1, mk(1, 1, 32'h22, 32'h22, 5'd18));
      tick();
      drive(1'b0, mk(0, 0, 0, 0, 0));
      repeat (6) tick();
      @(negedge clk);
      n_cmp++;
      if (STALL_CNT !== 16'd7 || READY_OUT !== 1'b0) begin
         n_bad++; $display("FAIL rs_pre: cnt %0d rdy %b want 7 0",
                           STALL_CNT, READY_OUT);
      end
      rst = 1'b1;
      tick();
      @(negedge clk);
      n_cmp++;
      if (STALL_CNT !== 16'd0 || VALID_OUT !== 1'b0 || got !== '0) begin
         n_bad++; $display("FAIL rs_rst: cnt %0d v %b pl %h want 0 0 0",
                           STALL_CNT, VALID_OUT, got);
      end
      rst = 1'b0;
      READY_IN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         n_cmp++;
         if (VALID_OUT !== 1'b0 || READY_OUT !== 1'b1) begin
            n_bad++; $display("FAIL rs_gone: v %b rdy %b want 0 1",
                              VALID_OUT, READY_OUT);
         end
      end
      tick();
   endtask

   task automatic test_saturation();
      mem_wb_t j;
      j = mk(1, 1, 32'hCAFEF00D, 32'h0BADF00D, 5'd9);
      READY_IN = 1'b0;
      drive(1'b1, j);
      tick();
      drive(1'b0, mk(0, 0, 0, 0, 0));
      repeat (10) tick();
      @(negedge clk);
      n_cmp++;
      if (STALL_CNT2 !== 3'd7) begin
         n_bad++; $display("FAIL sat_cnt3: got %0d want 7", STALL_CNT2);
      end
      n_cmp++;
      if (STALL_CNT !== 16'd10) begin
         n_bad++; $display("FAIL sat_cnt16: got %0d want 10", STALL_CNT);
      end
      n_cmp++;
      if (got2 !== j || VALID_OUT2 !== 1'b1 || READY_OUT2 !== 1'b1) begin
         n_bad++; $display("FAIL sat_hold: got %h v %b rdy %b want %h 1 1",
                           got2, VALID_OUT2, READY_OUT2, j);
      end
      READY_IN = 1'b1;
      tick();
      tick();
      @(negedge clk);
      n_cmp++;
      if (VALID_OUT !== 1'b0 || q.size() != 0 || STALL_CNT2 !== 3'd7) begin
         n_bad++; $display("FAIL sat_end: v %b pend %0d cnt %0d want 0 0 7",
                           VALID_OUT, q.size(), STALL_CNT2);
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_backpressure();
      test_flush();
      test_zero_guard();
      test_rst_mid_stall();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
